// File: rtl/error_combiner_pkg.sv
// rtl/error_combiner_pkg.sv - shared constants, width helpers and signed clamp for error_combiner
package error_combiner_pkg;

    localparam int NUM_CH = 4;

    // Wide container for the weighted sum. It is large enough for any legal
    // width combination, so the clamp helper can be width-agnostic.
    typedef logic signed [63:0] sum_word_t;

    function automatic int prod_width(input int weight_width, input int error_width);
        return weight_width + error_width;
    endfunction

    function automatic int sum_width(input int weight_width, input int error_width);
        return weight_width + error_width + 2;
    endfunction

    function automatic sum_word_t sat_to_width(input sum_word_t value, input int width);
        sum_word_t hi;
        sum_word_t lo;
        hi = (sum_word_t'(1) <<< (width - 1)) - sum_word_t'(1);
        lo = -hi - sum_word_t'(1);
        if (value > hi)
            return hi;
        if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/error_weight_mult.sv
// rtl/error_weight_mult.sv - one signed weight*error multiplier with registered full-width product
module error_weight_mult
    import error_combiner_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 4,
    parameter int ERROR_WIDTH  = 8,
    localparam int PW          = prod_width(WEIGHT_WIDTH, ERROR_WIDTH)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic signed [ERROR_WIDTH-1:0]  error,
    output logic signed [PW-1:0]           product
);

    // Both operands are widened before the multiply so the most negative
    // corner (-2^(W-1) * -2^(E-1)) stays exact.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            product <= '0;
        else
            product <= PW'(weight) * PW'(error);
    end

endmodule

// File: rtl/error_combiner.sv
// rtl/error_combiner.sv - weighted 4-channel phase-error combiner; ERROR_COMB_SAT_EN selects clamp vs wrap
module error_combiner
    import error_combiner_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 4,
    parameter int ERROR_WIDTH  = 8,
    parameter int NORM_SHIFT   = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_0_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_1_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_2_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_3_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_0_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_1_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_2_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_3_i,
    output logic signed [ERROR_WIDTH-1:0]  error_comb_o
);

    localparam int PW = prod_width(WEIGHT_WIDTH, ERROR_WIDTH);
    localparam int SW = sum_width(WEIGHT_WIDTH, ERROR_WIDTH);

    logic signed [WEIGHT_WIDTH-1:0] weight  [NUM_CH];
    logic signed [ERROR_WIDTH-1:0]  error   [NUM_CH];
    logic signed [PW-1:0]           product [NUM_CH];
    logic signed [SW-1:0]           sum;
    logic signed [SW-1:0]           shifted;
    logic signed [ERROR_WIDTH-1:0]  comb_next;

    assign weight[0] = weight_0_i;
    assign weight[1] = weight_1_i;
    assign weight[2] = weight_2_i;
    assign weight[3] = weight_3_i;
    assign error[0]  = error_0_i;
    assign error[1]  = error_1_i;
    assign error[2]  = error_2_i;
    assign error[3]  = error_3_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        error_weight_mult #(
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ERROR_WIDTH (ERROR_WIDTH)
        ) u_mult (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .weight (weight[k]),
            .error  (error[k]),
            .product(product[k])
        );
    end

    // Two guard bits above the product width absorb the four-way sum.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_CH; k++)
            sum = sum + SW'(product[k]);
        shifted = sum >>> NORM_SHIFT;
    end

`ifdef ERROR_COMB_SAT_EN
    assign comb_next = ERROR_WIDTH'(sat_to_width(sum_word_t'(shifted), ERROR_WIDTH));
`else
    assign comb_next = ERROR_WIDTH'(shifted);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            error_comb_o <= '0;
        else
            error_comb_o <= comb_next;
    end

endmodule

// File: tb/tb_error_combiner.sv
// tb/tb_error_combiner.sv - randomized and directed checks of error_combiner against a sum-of-products model
module tb_error_combiner;

    localparam int WW = 4;
    localparam int EW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [WW-1:0] w [4];
    logic signed [EW-1:0] e [4];
    logic signed [EW-1:0] out0;
    logic signed [EW-1:0] out2;

    int n_tests = 0;
    int n_fail  = 0;
    int hw [4];
    int he [4];
    int nedges = 0;

    always #5 clk = ~clk;

    error_combiner #(.WEIGHT_WIDTH(WW), .ERROR_WIDTH(EW), .NORM_SHIFT(0)) dut_s0 (
        .clk_i(clk), .reset_i(rst),
        .weight_0_i(w[0]), .weight_1_i(w[1]), .weight_2_i(w[2]), .weight_3_i(w[3]),
        .error_0_i(e[0]), .error_1_i(e[1]), .error_2_i(e[2]), .error_3_i(e[3]),
        .error_comb_o(out0)
    );

    error_combiner #(.WEIGHT_WIDTH(WW), .ERROR_WIDTH(EW), .NORM_SHIFT(2)) dut_s2 (
        .clk_i(clk), .reset_i(rst),
        .weight_0_i(w[0]), .weight_1_i(w[1]), .weight_2_i(w[2]), .weight_3_i(w[3]),
        .error_0_i(e[0]), .error_1_i(e[1]), .error_2_i(e[2]), .error_3_i(e[3]),
        .error_comb_o(out2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model(input int ws [4], input int es [4], input int sh);
        int s;
        int t;
        logic signed [7:0] b;
        s = 0;
        for (int k = 0; k < 4; k++)
            s += ws[k] * es[k];
        t = s >>> sh;
`ifdef ERROR_COMB_SAT_EN
        if (t > 127)
            t = 127;
        else if (t < -128)
            t = -128;
`else
        b = t[7:0];
        t = int'(b);
`endif
        return t;
    endfunction

    task automatic set_in(input int w0, input int w1, input int w2, input int w3,
                          input int e0, input int e1, input int e2, input int e3);
        w[0] = WW'(w0); w[1] = WW'(w1); w[2] = WW'(w2); w[3] = WW'(w3);
        e[0] = EW'(e0); e[1] = EW'(e1); e[2] = EW'(e2); e[3] = EW'(e3);
    endtask

    task automatic rand_in();
        for (int k = 0; k < 4; k++) begin
            w[k] = WW'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       e[k] = EW'(-128);
                1:       e[k] = EW'(127);
                default: e[k] = EW'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Output after an edge reflects the inputs captured at the previous edge,
    // provided at least one edge has passed since reset was released.
    task automatic tick();
        int x0;
        int x2;
        @(posedge clk);
        if (rst) begin
            x0 = 0;
            x2 = 0;
            nedges = 0;
        end else begin
            x0 = (nedges >= 1) ? model(hw, he, 0) : 0;
            x2 = (nedges >= 1) ? model(hw, he, 2) : 0;
            for (int k = 0; k < 4; k++) begin
                hw[k] = int'(w[k]);
                he[k] = int'(e[k]);
            end
            nedges++;
        end
        #1;
        check("pipe_s0", int'(out0), x0);
        check("pipe_s2", int'(out2), x2);
    endtask

    initial begin
        set_in(3, -2, 5, 7, 100, -50, 33, 12);
        #3;
        check("reset_now_s0", int'(out0), 0);
        check("reset_now_s2", int'(out2), 0);
        tick();
        tick();

        set_in(1, 1, 1, 1, 10, -40, 10, 10);
        #2 rst = 1'b0;
        tick();
        check("t2_first_edge", int'(out0), 0);
        tick();
        check("t2_sum", int'(out0), -10);
        check("t5_floor_shift", int'(out2), -3);

        set_in(1, 1, 1, 1, 10, 10, 10, 10);
        tick();
        tick();
        check("t5_shift_pos", int'(out2), 10);

        set_in(2, 0, 0, 0, 50, 99, -99, 7);
        tick();
        tick();
        check("t3_weight_zero", int'(out0), 100);

        set_in(-1, 0, 0, 0, -128, 0, 0, 0);
        tick();
        tick();
`ifdef ERROR_COMB_SAT_EN
        check("t3_neg_corner", int'(out0), 127);
`else
        check("t3_neg_corner", int'(out0), -128);
`endif

        set_in(7, 7, 7, 7, 127, 127, 127, 127);
        tick();
        tick();
`ifdef ERROR_COMB_SAT_EN
        check("t4_pos_sat", int'(out0), 127);
`else
        check("t4_pos_wrap", int'(out0), -28);
`endif

        set_in(-8, -8, -8, -8, 127, 127, 127, 127);
        tick();
        tick();
`ifdef ERROR_COMB_SAT_EN
        check("t4_neg_sat", int'(out0), -128);
`else
        check("t4_neg_wrap", int'(out0), 32);
`endif

        set_in(-8, -8, -8, -8, -128, -128, -128, -128);
        tick();
        tick();

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("all_zero", int'(out0), 0);

        for (int i = 0; i < 300; i++) begin
            rand_in();
            tick();
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 20; i++) begin
                rand_in();
                tick();
            end
            #2 rst = 1'b1;
            nedges = 0;
            #1;
            check("midrst_s0", int'(out0), 0);
            check("midrst_s2", int'(out2), 0);
            rand_in();
            tick();
            rand_in();
            #2 rst = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                rand_in();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
